// File: rtl/uart_word_rx_param.sv
// Assembles NBYTES received bytes into one word, optionally interleaved with
// position tags (k+1), with an inter-byte timeout that drops stalled frames.
module uart_word_rx_param #(
    parameter int NBYTES         = 4,
    parameter int TAGGED         = 1,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            byte_data,
    input  logic                  byte_valid,
    output logic [8*NBYTES-1:0]   word,
    output logic                  word_valid,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int KW         = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int CW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int T_LAST_INT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    localparam logic [KW-1:0] K_LAST = KW'(NBYTES - 1);
    localparam logic [CW-1:0] T_LAST = CW'(T_LAST_INT);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_TAG  = 2'd1;
    localparam logic [1:0] WAIT_DATA = 2'd2;
    localparam logic [1:0] DONE      = 2'd3;

    logic [1:0]          state, state_n;
    logic [KW-1:0]       k, k_n;
    logic [8*NBYTES-1:0] shadow, shadow_n;
    logic [CW-1:0]       cnt, cnt_n;
    logic                word_load;
    logic                err_n;
    logic                waiting;
    logic                timeout_hit;
    logic [7:0]          tag_expect;

    assign waiting     = (state == WAIT_TAG) || (state == WAIT_DATA);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && waiting && !byte_valid && (cnt == T_LAST);
    assign tag_expect  = 8'(k) + 8'd1;
    assign busy        = (state != IDLE);

    // DONE handles an incoming byte exactly like IDLE so back-to-back frames lose nothing.
    always_comb begin
        state_n   = state;
        k_n       = k;
        shadow_n  = shadow;
        word_load = 1'b0;
        err_n     = 1'b0;
        case (state)
            IDLE, DONE: begin
                state_n = IDLE;
                k_n     = '0;
                if (byte_valid) begin
                    if (TAGGED != 0) begin
                        if (byte_data == 8'd1) begin
                            state_n = WAIT_DATA;
                        end
                    end else begin
                        shadow_n[7:0] = byte_data;
                        if (NBYTES == 1) begin
                            state_n   = DONE;
                            word_load = 1'b1;
                        end else begin
                            state_n = WAIT_DATA;
                            k_n     = KW'(1);
                        end
                    end
                end
            end
            WAIT_DATA: begin
                if (byte_valid) begin
                    shadow_n[int'(k)*8 +: 8] = byte_data;
                    if (k == K_LAST) begin
                        state_n   = DONE;
                        word_load = 1'b1;
                        k_n       = '0;
                    end else begin
                        k_n     = k + KW'(1);
                        state_n = (TAGGED != 0) ? WAIT_TAG : WAIT_DATA;
                    end
                end else if (timeout_hit) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                    k_n     = '0;
                end
            end
            WAIT_TAG: begin
                if (byte_valid) begin
                    if (byte_data == tag_expect) begin
                        state_n = WAIT_DATA;
                    end else begin
                        err_n   = 1'b1;
                        k_n     = '0;
                        state_n = (byte_data == 8'd1) ? WAIT_DATA : IDLE;
                    end
                end else if (timeout_hit) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                    k_n     = '0;
                end
            end
            default: begin
                state_n = IDLE;
                k_n     = '0;
            end
        endcase
    end

    always_comb begin
        cnt_n = cnt;
        if (byte_valid || (state_n == IDLE) || (state_n == DONE)) begin
            cnt_n = '0;
        end else if (cnt != {CW{1'b1}}) begin
            cnt_n = cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            k          <= '0;
            shadow     <= '0;
            cnt        <= '0;
            word       <= '0;
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            k          <= k_n;
            shadow     <= shadow_n;
            cnt        <= cnt_n;
            word_valid <= word_load;
            frame_err  <= err_n;
            if (word_load) begin
                word <= shadow_n;
            end
        end
    end

endmodule

// File: tb/tb_uart_word_rx_param.sv
// Directed bench for uart_word_rx_param: a tagged 4-byte instance with a short
// timeout and a raw 2-byte instance, words checked through expectation queues.
module tb_uart_word_rx_param;

    logic        clk;
    logic        reset;
    logic [7:0]  byte_data_a, byte_data_b;
    logic        byte_valid_a, byte_valid_b;
    logic [31:0] word_a;
    logic [15:0] word_b;
    logic        word_valid_a, word_valid_b;
    logic        frame_err_a, frame_err_b;
    logic        busy_a, busy_b;

    int checks;
    int errors;
    int err_count_a;
    int err_count_b;

    logic [31:0] exp_q_a[$];
    logic [15:0] exp_q_b[$];
    logic [31:0] popped_a;
    logic [15:0] popped_b;

    uart_word_rx_param #(.NBYTES(4), .TAGGED(1), .TIMEOUT_CYCLES(50)) dut_a (
        .clk(clk), .reset(reset), .byte_data(byte_data_a), .byte_valid(byte_valid_a),
        .word(word_a), .word_valid(word_valid_a), .frame_err(frame_err_a), .busy(busy_a)
    );

    uart_word_rx_param #(.NBYTES(2), .TAGGED(0), .TIMEOUT_CYCLES(0)) dut_b (
        .clk(clk), .reset(reset), .byte_data(byte_data_b), .byte_valid(byte_valid_b),
        .word(word_b), .word_valid(word_valid_b), .frame_err(frame_err_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One-cycle strobe into the selected instance; returns just after the sampling edge.
    task automatic applyStimulus(input bit to_b, input logic [7:0] d);
        if (to_b) begin
            byte_data_b  = d;
            byte_valid_b = 1'b1;
        end else begin
            byte_data_a  = d;
            byte_valid_a = 1'b1;
        end
        @(posedge clk);
        #1;
        byte_valid_a = 1'b0;
        byte_valid_b = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sendFrameA(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 8'(i + 1));
            applyStimulus(1'b0, w[8*i +: 8]);
        end
    endtask

    // Word scoreboard and frame_err pulse counters.
    always @(negedge clk) begin
        if (!reset && word_valid_a) begin
            if (exp_q_a.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL a_unexpected_word: observed %h expected none", word_a);
            end else begin
                popped_a = exp_q_a.pop_front();
                checkOutput("a_word", 64'(word_a), 64'(popped_a));
            end
        end
        if (!reset && word_valid_b) begin
            if (exp_q_b.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL b_unexpected_word: observed %h expected none", word_b);
            end else begin
                popped_b = exp_q_b.pop_front();
                checkOutput("b_word", 64'(word_b), 64'(popped_b));
            end
        end
        if (!reset && frame_err_a) err_count_a++;
        if (!reset && frame_err_b) err_count_b++;
    end

    initial begin
        checks       = 0;
        errors       = 0;
        err_count_a  = 0;
        err_count_b  = 0;
        reset        = 1'b1;
        byte_data_a  = 8'h00;
        byte_data_b  = 8'h00;
        byte_valid_a = 1'b0;
        byte_valid_b = 1'b0;
        waitCycles(2);

        checkOutput("rst_word_a", 64'(word_a), 64'h0);
        checkOutput("rst_wv_a", 64'(word_valid_a), 64'h0);
        checkOutput("rst_err_a", 64'(frame_err_a), 64'h0);
        checkOutput("rst_busy_a", 64'(busy_a), 64'h0);
        checkOutput("rst_word_b", 64'(word_b), 64'h0);
        checkOutput("rst_busy_b", 64'(busy_b), 64'h0);
        reset = 1'b0;
        waitCycles(1);

        $display("[TB] tagged frame DEADBEEF");
        exp_q_a.push_back(32'hDEADBEEF);
        applyStimulus(1'b0, 8'h01); applyStimulus(1'b0, 8'hEF);
        applyStimulus(1'b0, 8'h02); applyStimulus(1'b0, 8'hBE);
        applyStimulus(1'b0, 8'h03); applyStimulus(1'b0, 8'hAD);
        applyStimulus(1'b0, 8'h04);
        checkOutput("busy_mid_frame", 64'(busy_a), 64'h1);
        checkOutput("wv_before_last", 64'(word_valid_a), 64'h0);
        applyStimulus(1'b0, 8'hDE);
        checkOutput("wv_latency", 64'(word_valid_a), 64'h1);
        checkOutput("word_deadbeef", 64'(word_a), 64'hDEADBEEF);
        checkOutput("busy_in_done", 64'(busy_a), 64'h1);
        waitCycles(1);
        checkOutput("wv_one_cycle", 64'(word_valid_a), 64'h0);
        checkOutput("busy_after_done", 64'(busy_a), 64'h0);
        checkOutput("no_err_good_frame", 64'(err_count_a), 64'h0);

        $display("[TB] stray byte in idle is discarded");
        applyStimulus(1'b0, 8'h07);
        checkOutput("stray_err", 64'(frame_err_a), 64'h0);
        checkOutput("stray_busy", 64'(busy_a), 64'h0);

        $display("[TB] tag mismatch then good frame");
        applyStimulus(1'b0, 8'h01); applyStimulus(1'b0, 8'h11);
        applyStimulus(1'b0, 8'h02); applyStimulus(1'b0, 8'h22);
        applyStimulus(1'b0, 8'h05);
        checkOutput("mismatch_err", 64'(frame_err_a), 64'h1);
        checkOutput("mismatch_busy", 64'(busy_a), 64'h0);
        waitCycles(1);
        checkOutput("mismatch_err_pulse", 64'(frame_err_a), 64'h0);
        checkOutput("mismatch_word_held", 64'(word_a), 64'hDEADBEEF);
        exp_q_a.push_back(32'h44332211);
        sendFrameA(32'h44332211);
        waitCycles(1);

        $display("[TB] resync on tag 01");
        exp_q_a.push_back(32'hDDCCBBAA);
        applyStimulus(1'b0, 8'h01); applyStimulus(1'b0, 8'h11);
        applyStimulus(1'b0, 8'h02); applyStimulus(1'b0, 8'h22);
        applyStimulus(1'b0, 8'h01);
        checkOutput("resync_err", 64'(frame_err_a), 64'h1);
        checkOutput("resync_busy", 64'(busy_a), 64'h1);
        applyStimulus(1'b0, 8'hAA); applyStimulus(1'b0, 8'h02);
        applyStimulus(1'b0, 8'hBB); applyStimulus(1'b0, 8'h03);
        applyStimulus(1'b0, 8'hCC); applyStimulus(1'b0, 8'h04);
        applyStimulus(1'b0, 8'hDD);
        checkOutput("resync_word", 64'(word_a), 64'hDDCCBBAA);
        waitCycles(2);
        checkOutput("err_count_after_resync", 64'(err_count_a), 64'h2);

        $display("[TB] timeout expiry");
        applyStimulus(1'b0, 8'h01); applyStimulus(1'b0, 8'h11);
        waitCycles(49);
        checkOutput("timeout_not_yet", 64'(frame_err_a), 64'h0);
        checkOutput("timeout_busy_before", 64'(busy_a), 64'h1);
        waitCycles(1);
        checkOutput("timeout_err", 64'(frame_err_a), 64'h1);
        checkOutput("timeout_idle", 64'(busy_a), 64'h0);
        waitCycles(5);
        checkOutput("timeout_single_pulse", 64'(err_count_a), 64'h3);
        checkOutput("timeout_word_held", 64'(word_a), 64'hDDCCBBAA);

        $display("[TB] byte coinciding with timeout expiry");
        exp_q_a.push_back(32'h44332211);
        applyStimulus(1'b0, 8'h01); applyStimulus(1'b0, 8'h11);
        waitCycles(49);
        applyStimulus(1'b0, 8'h02);
        checkOutput("coincide_no_err", 64'(frame_err_a), 64'h0);
        checkOutput("coincide_busy", 64'(busy_a), 64'h1);
        applyStimulus(1'b0, 8'h22); applyStimulus(1'b0, 8'h03);
        applyStimulus(1'b0, 8'h33); applyStimulus(1'b0, 8'h04);
        applyStimulus(1'b0, 8'h44);
        waitCycles(2);
        checkOutput("coincide_err_count", 64'(err_count_a), 64'h3);

        $display("[TB] raw two-byte frames with byte during DONE");
        exp_q_b.push_back(16'h1234);
        exp_q_b.push_back(16'h7856);
        applyStimulus(1'b1, 8'h34);
        checkOutput("raw_busy", 64'(busy_b), 64'h1);
        applyStimulus(1'b1, 8'h12);
        checkOutput("raw_wv", 64'(word_valid_b), 64'h1);
        checkOutput("raw_word", 64'(word_b), 64'h1234);
        applyStimulus(1'b1, 8'h56);
        checkOutput("raw_done_byte_wv", 64'(word_valid_b), 64'h0);
        checkOutput("raw_done_byte_busy", 64'(busy_b), 64'h1);
        applyStimulus(1'b1, 8'h78);
        checkOutput("raw_word2", 64'(word_b), 64'h7856);
        waitCycles(1);
        checkOutput("raw_idle", 64'(busy_b), 64'h0);
        checkOutput("raw_no_err", 64'(err_count_b), 64'h0);

        $display("[TB] reset mid-frame");
        applyStimulus(1'b0, 8'h01); applyStimulus(1'b0, 8'h11);
        applyStimulus(1'b0, 8'h02);
        reset = 1'b1;
        applyStimulus(1'b0, 8'h01);
        checkOutput("midrst_busy", 64'(busy_a), 64'h0);
        checkOutput("midrst_word", 64'(word_a), 64'h0);
        checkOutput("midrst_wv", 64'(word_valid_a), 64'h0);
        checkOutput("midrst_err", 64'(frame_err_a), 64'h0);
        reset = 1'b0;
        waitCycles(1);
        checkOutput("rst_input_ignored", 64'(busy_a), 64'h0);
        exp_q_a.push_back(32'h12345678);
        sendFrameA(32'h12345678);
        checkOutput("post_rst_word", 64'(word_a), 64'h12345678);
        waitCycles(3);
        checkOutput("final_err_count", 64'(err_count_a), 64'h3);
        checkOutput("queue_a_drained", 64'(exp_q_a.size()), 64'h0);
        checkOutput("queue_b_drained", 64'(exp_q_b.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
